// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and the
// parity helper used by both the transmit and (future) receive paths.
package uart_pkg;

  // 100 MHz core clock / 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  // Widest data field any UART frame in this core carries
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // XOR of the low nbits of data, inverted when odd parity is requested.
  // Bits above nbits are masked so callers may zero- or garbage-extend.
  function automatic logic calc_parity(
    input logic [MAX_DATA_BITS-1:0] data,
    input int unsigned              nbits,
    input logic                     odd
  );
    logic p;
    p = odd;
    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < nbits) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period strobe generator. Counts core clocks 0..CLKS_PER_BIT-1 and
// raises tick for the single cycle in which the count is at its maximum.
// clear restarts the period; the receiver will use it to align to mid-bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running period counter, restarted by reset or clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one data word per valid/ready handshake and
// serialises it as start, data LSB-first, optional parity, and stop bits.
// Bit timing is a strobe from uart_baud_gen in the core clock domain; all
// outputs come straight from flops so txd cannot glitch.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 txd,
  output logic                 busy
);

  // Reject configurations the datapath cannot represent
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned      IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             ODD_SEL   = (PARITY_ODD != 0);

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_parity;
  logic                 r_txd;
  logic                 r_s_ready;
  logic                 r_busy;

  logic                 w_fire;
  logic                 w_tick;

  // r_s_ready is only ever high in IDLE, so it alone qualifies the handshake
  assign w_fire = s_valid & r_s_ready;

  // Handshake restarts the bit period so the start bit is a full bit long
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (w_fire),
    .tick  (w_tick)
  );

  // Frame sequencer: state, shift register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_parity   <= 1'b0;
      r_txd      <= 1'b1;
      r_s_ready  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_shift    <= s_data;
            r_parity   <= calc_parity(MAX_DATA_BITS'(s_data), DATA_BITS, ODD_SEL);
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_txd      <= 1'b0;
            r_s_ready  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end else begin
            r_txd      <= 1'b1;
            r_s_ready  <= 1'b1;
            r_busy     <= 1'b0;
          end
        end

        ST_START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_txd   <= 1'b0;
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                r_txd   <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              // Next bit to send is shift[1]; it becomes shift[0] after the shift
              r_txd     <= r_shift[1];
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end else begin
            r_txd <= r_shift[0];
          end
        end

        ST_PARITY: begin
          if (w_tick) begin
            r_txd   <= 1'b1;
            r_state <= ST_STOP;
          end else begin
            r_txd   <= r_parity;
          end
        end

        ST_STOP: begin
          r_txd <= 1'b1;
          if (w_tick) begin
            if (r_stop_idx == LAST_STOP) begin
              r_s_ready <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end else begin
            r_stop_idx <= r_stop_idx;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_txd     <= 1'b1;
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign txd     = r_txd;
  assign s_ready = r_s_ready;
  assign busy    = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations share clk/rst; a select
// steers the handshake to one instance and muxes its outputs for checking.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic [1:0] sel;

  logic [3:0] w_valid;
  logic [3:0] txd_v;
  logic [3:0] rdy_v;
  logic [3:0] bsy_v;
  logic       m_txd;
  logic       m_rdy;
  logic       m_bsy;

  int checks = 0;
  int errors = 0;
  logic cap [0:63];

  always #5 clk = ~clk;

  assign w_valid[0] = s_valid && (sel == 2'd0);
  assign w_valid[1] = s_valid && (sel == 2'd1);
  assign w_valid[2] = s_valid && (sel == 2'd2);
  assign w_valid[3] = s_valid && (sel == 2'd3);

  // 8N1
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(w_valid[0]),
    .s_ready(rdy_v[0]), .txd(txd_v[0]), .busy(bsy_v[0]));
  // 8E1
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_8e1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(w_valid[1]),
    .s_ready(rdy_v[1]), .txd(txd_v[1]), .busy(bsy_v[1]));
  // 8O1
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_8o1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(w_valid[2]),
    .s_ready(rdy_v[2]), .txd(txd_v[2]), .busy(bsy_v[2]));
  // 5N2 at the minimum bit period
  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_5n2 (
    .clk(clk), .rst(rst), .s_data(s_data[4:0]), .s_valid(w_valid[3]),
    .s_ready(rdy_v[3]), .txd(txd_v[3]), .busy(bsy_v[3]));

  // Route the selected instance's outputs to the checkers
  always_comb begin
    m_txd = txd_v[0];
    m_rdy = rdy_v[0];
    m_bsy = bsy_v[0];
    case (sel)
      2'd0: begin m_txd = txd_v[0]; m_rdy = rdy_v[0]; m_bsy = bsy_v[0]; end
      2'd1: begin m_txd = txd_v[1]; m_rdy = rdy_v[1]; m_bsy = bsy_v[1]; end
      2'd2: begin m_txd = txd_v[2]; m_rdy = rdy_v[2]; m_bsy = bsy_v[2]; end
      2'd3: begin m_txd = txd_v[3]; m_rdy = rdy_v[3]; m_bsy = bsy_v[3]; end
      default: begin m_txd = 1'bx; m_rdy = 1'bx; m_bsy = 1'bx; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a word; the handshake happens at the following rising edge
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
  endtask

  // Check a frame cycle by cycle. bits[0] is the start bit. With keep_valid
  // the next word is loaded at the first frame cycle and left valid.
  task automatic frame(input logic [15:0] bits, input int nbits, input int cpb,
                       input int stop_after, input logic keep_valid,
                       input logic [7:0] next_data, input string tag);
    int total;
    total = nbits * cpb;
    for (int k = 0; (k < total) && (k < stop_after); k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (keep_valid) s_data = next_data;
        else            s_valid = 1'b0;
      end
      cap[k] = m_txd;
      chk($sformatf("%s txd cyc%0d", tag, k), 32'(m_txd), 32'(bits[k / cpb]));
      chk($sformatf("%s ready cyc%0d", tag, k), 32'(m_rdy), 32'd0);
      chk($sformatf("%s busy cyc%0d", tag, k), 32'(m_bsy), 32'd1);
    end
    if (stop_after >= total) begin
      @(negedge clk);
      chk($sformatf("%s end txd", tag), 32'(m_txd), 32'd1);
      chk($sformatf("%s end ready", tag), 32'(m_rdy), 32'd1);
      chk($sformatf("%s end busy", tag), 32'(m_bsy), 32'd0);
    end
  endtask

  // Receiver model: sample the captured line at the middle of each data bit
  function automatic logic [7:0] decode(input int nbits, input int cpb);
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      d[i] = cap[(1 + i) * cpb + cpb / 2];
    end
    return d;
  endfunction

  initial begin
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    sel     = 2'd0;

    // 1. Reset held three cycles with valid high: line idle, nothing accepted
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("reset txd c%0d", c), 32'(m_txd), 32'd1);
      chk($sformatf("reset ready c%0d", c), 32'(m_rdy), 32'd1);
      chk($sformatf("reset busy c%0d", c), 32'(m_bsy), 32'd0);
    end
    rst = 1'b0;

    // 2. 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1 at 4 clocks per bit
    frame({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, 999, 1'b0, 8'h00, "8n1_a5");

    // 3. Parity: even 0xA5 -> 0, even 0x01 -> 1, odd 0xA5 -> 1 (44 cycles)
    sel = 2'd1;
    send(8'hA5);
    frame({5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 999, 1'b0, 8'h00, "8e1_a5");
    send(8'h01);
    frame({5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 4, 999, 1'b0, 8'h00, "8e1_01");
    sel = 2'd2;
    send(8'hA5);
    frame({5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 4, 999, 1'b0, 8'h00, "8o1_a5");

    // 4. Back-to-back: one idle-high clock between frames (start-to-start 41)
    sel = 2'd0;
    send(8'h00);
    frame({6'b0, 1'b1, 8'h00, 1'b0}, 10, 4, 999, 1'b1, 8'hFF, "b2b_00");
    frame({6'b0, 1'b1, 8'hFF, 1'b0}, 10, 4, 999, 1'b0, 8'h00, "b2b_ff");

    // 5. Reset during data bit 3 of 0x55 (frame cycles 16..19)
    send(8'h55);
    frame({6'b0, 1'b1, 8'h55, 1'b0}, 10, 4, 18, 1'b0, 8'h00, "mid_55");
    rst = 1'b1;
    @(negedge clk);
    chk("midrst txd", 32'(m_txd), 32'd1);
    chk("midrst ready", 32'(m_rdy), 32'd1);
    chk("midrst busy", 32'(m_bsy), 32'd0);
    rst = 1'b0;
    send(8'h0F);
    frame({6'b0, 1'b1, 8'h0F, 1'b0}, 10, 4, 999, 1'b0, 8'h00, "after_rst_0f");
    chk("after_rst decode", 32'(decode(8, 4)), 32'h0F);

    // 6. Minimum bit period, 5 data bits, 2 stop bits: 16-cycle frame
    sel = 2'd3;
    send(8'h1F);
    frame({8'b0, 2'b11, 5'h1F, 1'b0}, 8, 2, 999, 1'b0, 8'h00, "5n2_1f");
    chk("5n2 decode", 32'(decode(5, 2)), 32'h1F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
